sd_data_control: RTL and testbench

//  Sequencing FSM of the SD host DATA block. Accepts a transfer request (direction, block count, timeout),

---
 rtl/sd_data_control_pkg.sv | 22 ++
 rtl/sd_data_control_if.sv | 37 +++
 rtl/sd_data_control_timeout.sv | 29 ++
 rtl/sd_data_control.sv | 111 +++++++++++
 tb/tb_sd_data_control.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_data_control_pkg.sv
// Shared definitions for the SD host DATA sequencing controller: state codes and default widths.
package sd_data_control_pkg;

  localparam int BLOCKS_W_DEF  = 8;
  localparam int TIMEOUT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETTING    = 3'd1,
    CHECK_FIFO = 3'd2,
    TRANSMIT   = 3'd3,
    ACK        = 3'd4,
    DONE       = 3'd5,
    TOUT       = 3'd6
  } state_e;

  // States whose dwell time is watched by the timeout counter.
  function automatic logic is_supervised(input state_e s);
    return (s == CHECK_FIFO) || (s == TRANSMIT);
  endfunction

endpackage

// File: rtl/sd_data_control_if.sv
// Request, FIFO and physical-layer handshake bundle between the DMA/PHY side and sd_data_control.
interface sd_data_control_if
  import sd_data_control_pkg::*;
#(
  parameter int BLOCKS_W  = BLOCKS_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
);
  logic                 NewData;
  logic                 WriteRead;
  logic [BLOCKS_W-1:0]  Blocks;
  logic                 MultipleData;
  logic                 Timeout_enable;
  logic [TIMEOUT_W-1:0] Timeout_reg;
  logic                 FIFO_ok;
  logic                 Serial_ready;
  logic                 Complete;
  logic                 Ack_in;
  logic                 Send;
  logic                 Ack_out;
  logic                 Idle;
  logic                 Direction;
  logic                 Data_transfer_complete;
  logic                 Timeout;
  logic [BLOCKS_W-1:0]  Block_count;

  modport master (
    output NewData, WriteRead, Blocks, MultipleData, Timeout_enable, Timeout_reg,
           FIFO_ok, Serial_ready, Complete, Ack_in,
    input  Send, Ack_out, Idle, Direction, Data_transfer_complete, Timeout, Block_count
  );

  modport slave (
    input  NewData, WriteRead, Blocks, MultipleData, Timeout_enable, Timeout_reg,
           FIFO_ok, Serial_ready, Complete, Ack_in,
    output Send, Ack_out, Idle, Direction, Data_transfer_complete, Timeout, Block_count
  );
endinterface

// File: rtl/sd_data_control_timeout.sv
// Dwell-time counter: cleared on state entry, counts while enabled, flags the limit-th cycle.
module sd_timeout_counter #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [TIMEOUT_W-1:0] limit_i,
  output logic                 expired_o
);
  localparam logic [TIMEOUT_W-1:0] ONE = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  // A zero limit disables supervision rather than expiring immediately.
  assign expired_o = enable_i && (limit_i != '0) && (cnt_q == (limit_i - ONE));

endmodule

// File: rtl/sd_data_control.sv
// Block sequencing FSM of the SD host DATA path: start latch, FIFO/PHY gating, Send/Ack handshakes, block count.
module sd_data_control
  import sd_data_control_pkg::*;
#(
  parameter int BLOCKS_W  = BLOCKS_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  sd_data_control_if.slave bus
);
  localparam logic [BLOCKS_W-1:0] ONE_B = BLOCKS_W'(1);

  state_e               state_q, state_d;
  logic                 dir_q, dir_d;
  logic                 ten_q, ten_d;
  logic [TIMEOUT_W-1:0] treg_q, treg_d;
  logic [BLOCKS_W-1:0]  target_q, target_d;
  logic [BLOCKS_W-1:0]  count_q, count_d;

  logic                 tmr_clear;
  logic                 tmr_enable;
  logic [TIMEOUT_W-1:0] tmr_limit;
  logic                 tmr_expired;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      ten_q    <= 1'b0;
      treg_q   <= '0;
      target_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      ten_q    <= ten_d;
      treg_q   <= treg_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    ten_d    = ten_q;
    treg_d   = treg_q;
    target_d = target_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.NewData && (bus.Blocks != '0)) begin
          state_d  = SETTING;
          dir_d    = bus.WriteRead;
          ten_d    = bus.Timeout_enable;
          treg_d   = bus.Timeout_reg;
          target_d = bus.MultipleData ? bus.Blocks : ONE_B;
        end
      end
      SETTING: begin
        count_d = '0;
        state_d = CHECK_FIFO;
      end
      // Exit conditions are tested before expiry so a late-but-in-time response still wins.
      CHECK_FIFO: begin
        if (bus.FIFO_ok && bus.Serial_ready) state_d = TRANSMIT;
        else if (tmr_expired)                state_d = TOUT;
      end
      TRANSMIT: begin
        if (bus.Complete) begin
          count_d = count_q + ONE_B;
          state_d = ACK;
        end else if (tmr_expired) begin
          state_d = TOUT;
        end
      end
      ACK: begin
        if (bus.Ack_in) state_d = (count_q == target_q) ? DONE : CHECK_FIFO;
      end
      DONE:    state_d = IDLE;
      TOUT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every entry into a supervised state, including CHECK_FIFO -> TRANSMIT.
  assign tmr_clear  = is_supervised(state_d) && (state_d != state_q);
  assign tmr_enable = is_supervised(state_q);
  assign tmr_limit  = ten_q ? treg_q : '0;

  sd_timeout_counter #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .Clock     (Clock),
    .Reset     (Reset),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .limit_i   (tmr_limit),
    .expired_o (tmr_expired)
  );

  assign bus.Send                   = (state_q == TRANSMIT);
  assign bus.Ack_out                = (state_q == ACK);
  assign bus.Idle                   = (state_q == IDLE);
  assign bus.Data_transfer_complete = (state_q == DONE);
  assign bus.Timeout                = (state_q == TOUT);
  assign bus.Direction              = dir_q;
  assign bus.Block_count            = count_q;

endmodule

// File: tb/tb_sd_data_control.sv
// Scoreboard bench for sd_data_control: reactive PHY/FIFO model, transfer-level reference model, event monitor.
module tb_sd_data_control;
  localparam int BW = 8;
  localparam int TW = 16;

  typedef struct {
    bit tout;
    int cnt;
    int sends;
    bit dir;
    int lat;
    int slat;
    int nd;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  int cpl_dly = 1, ack_dly = 1, fifo_mode = 0, stall_blk = 0;
  bit noise = 1'b0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  sd_data_control_if #(.BLOCKS_W(BW), .TIMEOUT_W(TW)) bus ();

  sd_data_control #(.BLOCKS_W(BW), .TIMEOUT_W(TW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // PHY / FIFO responder: Complete on the d-th Send cycle, Ack_in on the a-th Ack_out cycle.
  int tx_run = 0, ack_run = 0;
  always @(negedge Clock) begin
    if (Reset) begin
      tx_run = 0; ack_run = 0;
      bus.Complete = 1'b0; bus.Ack_in = 1'b0;
    end else begin
      tx_run  = bus.Send    ? tx_run + 1  : 0;
      ack_run = bus.Ack_out ? ack_run + 1 : 0;
      bus.Complete = bus.Send    ? (tx_run == cpl_dly)  : (noise && ($urandom_range(0, 3) == 0));
      bus.Ack_in   = bus.Ack_out ? (ack_run == ack_dly) : (noise && ($urandom_range(0, 3) == 0));
      case (fifo_mode)
        1: begin
          bus.FIFO_ok      = 1'($urandom_range(0, 1));
          bus.Serial_ready = 1'($urandom_range(0, 1));
        end
        2: begin
          bus.FIFO_ok      = (int'(bus.Block_count) < stall_blk);
          bus.Serial_ready = 1'b1;
        end
        default: begin
          bus.FIFO_ok      = 1'b1;
          bus.Serial_ready = 1'b1;
        end
      endcase
    end
  end

  // Monitor: counts Send episodes and pops one expectation per DTC/Timeout pulse.
  int  sends_seen = 0;
  int  first_send = -1;
  bit  send_prev  = 1'b0;
  always @(negedge Clock) begin
    exp_t e;
    if (Reset) begin
      sends_seen = 0; first_send = -1; send_prev = 1'b0;
    end else begin
      if (bus.Send && !send_prev) begin
        sends_seen++;
        if (first_send < 0) first_send = cyc;
      end
      send_prev = bus.Send;
      if (bus.Data_transfer_complete || bus.Timeout) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event_queue_size", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_timeout", int'(bus.Timeout), int'(e.tout));
          chk("event_is_dtc", int'(bus.Data_transfer_complete), int'(!e.tout));
          chk("event_block_count", int'(bus.Block_count), e.cnt);
          chk("event_send_episodes", sends_seen, e.sends);
          chk("event_direction", int'(bus.Direction), int'(e.dir));
          chk("event_idle", int'(bus.Idle), 0);
          if (e.lat >= 0)  chk("event_latency", cyc - e.nd, e.lat);
          if (e.slat >= 0) chk("send_latency", first_send - e.nd, e.slat);
        end
        sends_seen = 0; first_send = -1;
      end
    end
  end

  task automatic run_txn(input bit wr, input int blocks, input bit multi, input bit ten,
                         input int treg, input int d, input int a, input bit nz,
                         input int fm, input int stall, input bit ndn);
    exp_t e;
    int   n, per;
    bit   sup, ok;
    n   = multi ? blocks : 1;
    sup = ten && (treg != 0);
    per = 1 + d + a;
    e.tout = 1'b0; e.cnt = 0; e.sends = 0; e.dir = wr; e.lat = -1; e.slat = -1;
    for (int i = 0; i < n; i++) begin
      if (fm == 2 && i >= stall) begin
        e.tout = 1'b1; e.lat = 2 + i * per + treg; break;
      end
      e.sends++;
      if (sup && d > treg) begin
        e.tout = 1'b1; e.lat = 2 + i * per + 1 + treg; break;
      end
      e.cnt++;
    end
    if (!e.tout) e.lat = 2 + n * per;
    if (fm == 1) e.lat = -1;
    if (fm != 1 && e.sends > 0) e.slat = 3;

    @(negedge Clock);
    cpl_dly = d; ack_dly = a; noise = nz; fifo_mode = fm; stall_blk = stall;
    bus.WriteRead = wr; bus.Blocks = BW'(blocks); bus.MultipleData = multi;
    bus.Timeout_enable = ten; bus.Timeout_reg = TW'(treg); bus.NewData = 1'b1;
    e.nd = cyc;
    exp_q.push_back(e);
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge Clock);
      if (bus.Idle) begin
        bus.NewData = 1'b0; ok = 1'b1; break;
      end
      if (ndn) begin
        bus.NewData = 1'($urandom_range(0, 1));
        bus.Blocks  = BW'($urandom_range(0, 255));
      end else begin
        bus.NewData = 1'b0;
      end
    end
    if (!ok) begin
      chk("return_to_idle_within_budget", 0, 1);
      bus.NewData = 1'b0;
      Reset = 1'b1; @(negedge Clock); @(negedge Clock); Reset = 1'b0;
      exp_q.delete();
    end else begin
      chk("idle_block_count", int'(bus.Block_count), e.cnt);
    end
  endtask

  task automatic reset_mid();
    bit found;
    @(negedge Clock);
    cpl_dly = 8; ack_dly = 2; noise = 1'b0; fifo_mode = 0;
    bus.WriteRead = 1'b1; bus.Blocks = 8'd4; bus.MultipleData = 1'b1;
    bus.Timeout_enable = 1'b0; bus.Timeout_reg = '0; bus.NewData = 1'b1;
    @(negedge Clock);
    bus.NewData = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (bus.Send && bus.Block_count == 8'd1) begin
        found = 1'b1; break;
      end
      @(negedge Clock);
    end
    chk("reached_block2_transmit", int'(found), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_send", int'(bus.Send), 0);
    chk("async_reset_idle", int'(bus.Idle), 1);
    chk("async_reset_block_count", int'(bus.Block_count), 0);
    chk("async_reset_ack_out", int'(bus.Ack_out), 0);
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    int blk, fm, treg, stall;
    bit ten, multi;
    Reset = 1'b1;
    bus.NewData = 1'b0; bus.WriteRead = 1'b0; bus.Blocks = '0; bus.MultipleData = 1'b0;
    bus.Timeout_enable = 1'b0; bus.Timeout_reg = '0; bus.FIFO_ok = 1'b0;
    bus.Serial_ready = 1'b0; bus.Complete = 1'b0; bus.Ack_in = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_send", int'(bus.Send), 0);
    chk("reset_ack_out", int'(bus.Ack_out), 0);
    chk("reset_idle", int'(bus.Idle), 1);
    chk("reset_direction", int'(bus.Direction), 0);
    chk("reset_dtc", int'(bus.Data_transfer_complete), 0);
    chk("reset_timeout", int'(bus.Timeout), 0);
    chk("reset_block_count", int'(bus.Block_count), 0);
    Reset = 1'b0;

    run_txn(1, 1, 0, 0, 0, 10, 2, 0, 0, 0, 0);     // single write
    run_txn(0, 3, 1, 0, 0, 5, 3, 0, 0, 0, 0);      // three-block read
    run_txn(1, 5, 0, 0, 0, 4, 1, 0, 0, 0, 0);      // single forced despite Blocks=5
    run_txn(1, 2, 1, 1, 70, 3, 1, 0, 2, 0, 0);     // FIFO never ready -> timeout in CHECK_FIFO
    reset_mid();
    run_txn(0, 2, 1, 0, 0, 3, 2, 0, 0, 0, 0);      // normal run after reset
    run_txn(1, 1, 0, 1, 70, 70, 2, 0, 0, 0, 1);    // Complete in expiry cycle wins
    run_txn(1, 1, 0, 1, 70, 71, 2, 0, 0, 0, 1);    // one cycle late -> timeout in TRANSMIT

    @(negedge Clock);
    bus.Blocks = '0; bus.NewData = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      bus.NewData = 1'b0;
      chk("zero_blocks_idle", int'(bus.Idle), 1);
    end

    run_txn(1, 255, 1, 1, 1, 1, 1, 0, 0, 0, 0);    // full-width count, limit of one cycle
    run_txn(0, 2, 1, 1, 0, 30, 1, 0, 0, 0, 0);     // limit zero disables supervision
    run_txn(1, 4, 1, 1, 6, 2, 2, 1, 2, 2, 0);      // FIFO stall at third block

    for (int t = 0; t < 30; t++) begin
      blk   = $urandom_range(1, 6);
      multi = 1'($urandom_range(0, 1));
      fm    = $urandom_range(0, 2);
      ten   = 1'($urandom_range(0, 1));
      treg  = $urandom_range(1, 15);
      stall = $urandom_range(0, 5);
      if (fm == 1) begin
        if ($urandom_range(0, 1) == 1) ten = 1'b0; else treg = 0;
      end
      if (fm == 2) ten = 1'b1;
      run_txn(1'($urandom_range(0, 1)), blk, multi, ten, treg, $urandom_range(1, 15),
              $urandom_range(1, 4), 1'($urandom_range(0, 1)), fm, stall,
              1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge Clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
